// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_arb_pkg;

  localparam int unsigned DATA_W         = 16;
  localparam int unsigned ADDR_W         = 4;
  localparam int unsigned NUM_REGS       = 2 ** ADDR_W;
  localparam int unsigned DEF_FIFO_DEPTH = 2;
  localparam int unsigned TAG_W          = $clog2(2 * DEF_FIFO_DEPTH) + 1;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    tag_t              tag;
  } wb_entry_t;

  // tag_a is older than tag_b when b is ahead of a by less than half the tag space
  function automatic logic older(tag_t tag_a, tag_t tag_b);
    tag_t diff;
    diff = tag_b - tag_a;
    return (diff != '0) && !diff[TAG_W-1];
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Per-requester writeback FIFO with a per-slot valid view for the pending mask.
module rf_wb_fifo
  import rf_arb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = rf_arb_pkg::DEF_FIFO_DEPTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 push_i,
  input  wb_entry_t                            entry_i,
  input  logic                                 pop_i,
  output wb_entry_t                            head_o,
  output logic                                 full_o,
  output logic                                 empty_o,
  output logic [FIFO_DEPTH-1:0]                vlds_o,
  output logic [FIFO_DEPTH-1:0][ADDR_W-1:0]    addrs_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  wb_entry_t [FIFO_DEPTH-1:0] mem_q;
  logic [FIFO_DEPTH-1:0]      vld_q, vld_d;
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;

  // Pop clears before push sets, so a full FIFO can pop and refill the same slot
  always_comb begin
    vld_d = vld_q;
    if (pop_i)  vld_d[rd_ptr_q] = 1'b0;
    if (push_i) vld_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (push_i) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) addrs_o[i] = mem_q[i].addr;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = &vld_q;
  assign empty_o = ~|vld_q;
  assign vlds_o  = vld_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates ALU and load-return writebacks onto the single registered RF write port.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = rf_arb_pkg::DATA_W,
  parameter int unsigned ADDR_W     = rf_arb_pkg::ADDR_W,
  parameter int unsigned FIFO_DEPTH = rf_arb_pkg::DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_vld,
  output logic                  alu_rdy,
  input  logic [ADDR_W-1:0]     alu_addr,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_vld,
  output logic                  mem_rdy,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  rf_we,
  output logic [ADDR_W-1:0]     rf_dst_addr,
  output logic [DATA_W-1:0]     rf_dst,
  output logic [2**ADDR_W-1:0]  pend_mask,
  output logic                  idle
);

  logic                             alu_full, alu_empty, mem_full, mem_empty;
  logic                             alu_acc, mem_acc, gnt_alu, gnt_mem;
  wb_entry_t                        alu_in, mem_in, alu_head, mem_head, gnt_entry;
  logic [FIFO_DEPTH-1:0]            alu_vlds, mem_vlds;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] alu_addrs, mem_addrs;

  tag_t              tag_q, tag_d;
  logic              rr_mem_q, rr_mem_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  assign alu_rdy = rst_n && !alu_full;
  assign mem_rdy = rst_n && !mem_full;
  assign alu_acc = alu_vld && alu_rdy;
  assign mem_acc = mem_vld && mem_rdy;

  // A same-edge load return takes the lower tag so it counts as older than the ALU result
  assign mem_in = '{addr: mem_addr, data: mem_data, tag: tag_q};
  assign alu_in = '{addr: alu_addr, data: alu_data, tag: tag_q + TAG_W'(mem_acc)};
  assign tag_d  = tag_q + TAG_W'(alu_acc) + TAG_W'(mem_acc);

  rf_wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(alu_acc), .entry_i(alu_in), .pop_i(gnt_alu),
    .head_o(alu_head), .full_o(alu_full), .empty_o(alu_empty),
    .vlds_o(alu_vlds), .addrs_o(alu_addrs)
  );

  rf_wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(mem_acc), .entry_i(mem_in), .pop_i(gnt_mem),
    .head_o(mem_head), .full_o(mem_full), .empty_o(mem_empty),
    .vlds_o(mem_vlds), .addrs_o(mem_addrs)
  );

  // WAW on the heads overrides round-robin so writes to one register retire in age order
  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    if (!alu_empty && !mem_empty) begin
      if (alu_head.addr == mem_head.addr) begin
        if (older(alu_head.tag, mem_head.tag)) gnt_alu = 1'b1;
        else                                   gnt_mem = 1'b1;
      end else if (rr_mem_q) begin
        gnt_mem = 1'b1;
      end else begin
        gnt_alu = 1'b1;
      end
    end else if (!alu_empty) begin
      gnt_alu = 1'b1;
    end else if (!mem_empty) begin
      gnt_mem = 1'b1;
    end
  end

  always_comb begin
    gnt_entry = gnt_mem ? mem_head : alu_head;
    rr_mem_d  = rr_mem_q;
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (gnt_alu || gnt_mem) begin
      rr_mem_d  = gnt_alu;
      rf_we_d   = (gnt_entry.addr != '0);
      rf_addr_d = gnt_entry.addr;
      rf_data_d = gnt_entry.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q     <= '0;
      rr_mem_q  <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      tag_q     <= tag_d;
      rr_mem_q  <= rr_mem_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Register 0 is never marked: it is never written
  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (alu_vlds[i] && alu_addrs[i] != '0) pend_mask[alu_addrs[i]] = 1'b1;
      if (mem_vlds[i] && mem_addrs[i] != '0) pend_mask[mem_addrs[i]] = 1'b1;
    end
    if (rf_we_q) pend_mask[rf_addr_q] = 1'b1;
  end

  assign rf_we       = rf_we_q;
  assign rf_dst_addr = rf_addr_q;
  assign rf_dst      = rf_data_q;
  assign idle        = alu_empty && mem_empty && !rf_we_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed vector table, corner sequences, random vs queue model.
module tb_rf_write_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_vld, mem_vld;
  logic        alu_rdy, mem_rdy;
  logic [3:0]  alu_addr, mem_addr;
  logic [15:0] alu_data, mem_data;
  logic        rf_we;
  logic [3:0]  rf_dst_addr;
  logic [15:0] rf_dst;
  logic [15:0] pend_mask;
  logic        idle;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_vld(alu_vld), .alu_rdy(alu_rdy), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_vld(mem_vld), .mem_rdy(mem_rdy), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_we(rf_we), .rf_dst_addr(rf_dst_addr), .rf_dst(rf_dst),
    .pend_mask(pend_mask), .idle(idle)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queues with unbounded sequence numbers for age
  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    int          seq;
  } ment_t;

  ment_t       aq[$];
  ment_t       mq[$];
  int          m_seq;
  bit          m_rr_mem;
  logic        m_we;
  logic [3:0]  m_addr;
  logic [15:0] m_data;

  function automatic logic [15:0] model_mask();
    logic [15:0] m;
    m = '0;
    foreach (aq[i]) if (aq[i].addr != 4'd0) m[aq[i].addr] = 1'b1;
    foreach (mq[i]) if (mq[i].addr != 4'd0) m[mq[i].addr] = 1'b1;
    if (m_we) m[m_addr] = 1'b1;
    return m;
  endfunction

  function automatic bit model_idle();
    return (aq.size() == 0) && (mq.size() == 0) && !m_we;
  endfunction

  task automatic model_reset();
    aq.delete();
    mq.delete();
    m_seq    = 0;
    m_rr_mem = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_data   = '0;
  endtask

  task automatic model_step(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                            input logic mv, input logic [3:0] ma, input logic [15:0] md,
                            output bit a_acc, output bit m_acc);
    int    g;
    ment_t h;
    a_acc = av && (aq.size() < DEPTH);
    m_acc = mv && (mq.size() < DEPTH);
    g = 0;
    if (aq.size() > 0 && mq.size() > 0) begin
      if (aq[0].addr == mq[0].addr) g = (aq[0].seq < mq[0].seq) ? 1 : 2;
      else                          g = m_rr_mem ? 2 : 1;
    end else if (aq.size() > 0) g = 1;
    else if (mq.size() > 0)     g = 2;
    m_we = 1'b0;
    if (g != 0) begin
      if (g == 1) begin h = aq.pop_front(); m_rr_mem = 1'b1; end
      else        begin h = mq.pop_front(); m_rr_mem = 1'b0; end
      m_we   = (h.addr != 4'd0);
      m_addr = h.addr;
      m_data = h.data;
    end
    if (m_acc) begin mq.push_back('{ma, md, m_seq}); m_seq++; end
    if (a_acc) begin aq.push_back('{aa, ad, m_seq}); m_seq++; end
  endtask

  // One clock: drive, advance model at the edge, compare on the falling edge
  task automatic cycle(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                       input logic mv, input logic [3:0] ma, input logic [15:0] md,
                       output bit a_acc, output bit m_acc);
    alu_vld = av; alu_addr = aa; alu_data = ad;
    mem_vld = mv; mem_addr = ma; mem_data = md;
    @(posedge clk);
    model_step(av, aa, ad, mv, ma, md, a_acc, m_acc);
    @(negedge clk);
    chk("rf_we", 32'(rf_we), 32'(m_we));
    chk("rf_dst_addr", 32'(rf_dst_addr), 32'(m_addr));
    chk("rf_dst", 32'(rf_dst), 32'(m_data));
    chk("pend_mask", 32'(pend_mask), 32'(model_mask()));
    chk("idle", 32'(idle), 32'(model_idle()));
    chk("alu_rdy", 32'(alu_rdy), 32'(aq.size() < DEPTH));
    chk("mem_rdy", 32'(mem_rdy), 32'(mq.size() < DEPTH));
  endtask

  typedef struct {
    logic        av;
    logic [3:0]  aa;
    logic [15:0] ad;
    logic        mv;
    logic [3:0]  ma;
    logic [15:0] md;
    logic        ewe;
    logic [3:0]  eaddr;
    logic [15:0] edata;
    logic [15:0] emask;
  } vec_t;

  vec_t vt[19];

  initial begin
    bit          a_acc, m_acc;
    int          ai, mi;
    bit          saw_low;
    logic [15:0] got[$];
    logic        ra_v, rm_v;
    logic [3:0]  ra_a, rm_a;
    logic [15:0] ra_d, rm_d;

    // contention, single write, WAW with both rr states, R0, WAW across tag wrap
    vt[0]  = '{1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 4'd0, 16'h0000, 16'h0006};
    vt[1]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd1, 16'h1111, 16'h0006};
    vt[2]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 16'h2222, 16'h0004};
    vt[3]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd2, 16'h2222, 16'h0000};
    vt[4]  = '{1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd2, 16'h2222, 16'h0008};
    vt[5]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 16'hBEEF, 16'h0008};
    vt[6]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd3, 16'hBEEF, 16'h0000};
    vt[7]  = '{1'b1, 4'd5, 16'hBBBB, 1'b1, 4'd5, 16'hAAAA, 1'b0, 4'd3, 16'hBEEF, 16'h0020};
    vt[8]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 16'hAAAA, 16'h0020};
    vt[9]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 16'hBBBB, 16'h0020};
    vt[10] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd5, 16'hBBBB, 16'h0000};
    vt[11] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 16'h0007, 1'b0, 4'd5, 16'hBBBB, 16'h0080};
    vt[12] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 16'h0007, 16'h0080};
    vt[13] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd7, 16'h0007, 16'h0000};
    vt[14] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'hFFFF, 16'h0000};
    vt[15] = '{1'b1, 4'd6, 16'hDDDD, 1'b1, 4'd6, 16'hCCCC, 1'b0, 4'd0, 16'hFFFF, 16'h0040};
    vt[16] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd6, 16'hCCCC, 16'h0040};
    vt[17] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd6, 16'hDDDD, 16'h0040};
    vt[18] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd6, 16'hDDDD, 16'h0000};

    // Reset held with a request pending
    rst_n = 1'b0;
    alu_vld = 1'b1; alu_addr = 4'd3; alu_data = 16'h1234;
    mem_vld = 1'b0; mem_addr = 4'd0; mem_data = 16'h0000;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst alu_rdy", 32'(alu_rdy), 32'd0);
    chk("rst mem_rdy", 32'(mem_rdy), 32'd0);
    chk("rst rf_we", 32'(rf_we), 32'd0);
    chk("rst rf_dst_addr", 32'(rf_dst_addr), 32'd0);
    chk("rst rf_dst", 32'(rf_dst), 32'd0);
    chk("rst pend_mask", 32'(pend_mask), 32'd0);
    chk("rst idle", 32'(idle), 32'd1);
    alu_vld = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("rel alu_rdy", 32'(alu_rdy), 32'd1);
    chk("rel mem_rdy", 32'(mem_rdy), 32'd1);

    // Directed vector table
    for (int i = 0; i < 19; i++) begin
      cycle(vt[i].av, vt[i].aa, vt[i].ad, vt[i].mv, vt[i].ma, vt[i].md, a_acc, m_acc);
      chk($sformatf("vec%0d rf_we", i), 32'(rf_we), 32'(vt[i].ewe));
      chk($sformatf("vec%0d addr", i), 32'(rf_dst_addr), 32'(vt[i].eaddr));
      chk($sformatf("vec%0d data", i), 32'(rf_dst), 32'(vt[i].edata));
      chk($sformatf("vec%0d mask", i), 32'(pend_mask), 32'(vt[i].emask));
      if (i == 6 || i == 18) chk($sformatf("vec%0d idle", i), 32'(idle), 32'd1);
    end

    // Backpressure: alu holds each value until accepted while mem competes for the port
    ai = 0; mi = 0; saw_low = 1'b0;
    for (int c = 0; c < 16; c++) begin
      cycle(ai < 3, 4'(8 + ai), 16'(32'hA000 + ai), mi < 4, 4'd12, 16'(32'hC000 + mi), a_acc, m_acc);
      if (a_acc) ai++;
      if (m_acc) mi++;
      if (!alu_rdy) saw_low = 1'b1;
      if (rf_we && rf_dst_addr >= 4'd8 && rf_dst_addr <= 4'd10) got.push_back(rf_dst);
    end
    chk("bp alu_rdy dropped", 32'(saw_low), 32'd1);
    chk("bp alu accepted", 32'(ai), 32'd3);
    chk("bp alu writes", 32'(got.size()), 32'd3);
    for (int k = 0; k < got.size() && k < 3; k++)
      chk($sformatf("bp order%0d", k), 32'(got[k]), 32'hA000 + 32'(k));

    // Reset with three writes outstanding
    cycle(1'b1, 4'd1, 16'h0101, 1'b1, 4'd2, 16'h0202, a_acc, m_acc);
    cycle(1'b1, 4'd3, 16'h0303, 1'b1, 4'd4, 16'h0404, a_acc, m_acc);
    chk("pre-reset rf_we", 32'(rf_we), 32'd1);
    alu_vld = 1'b0; mem_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst rf_we", 32'(rf_we), 32'd0);
    chk("midrst pend_mask", 32'(pend_mask), 32'd0);
    chk("midrst idle", 32'(idle), 32'd1);
    chk("midrst alu_rdy", 32'(alu_rdy), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, a_acc, m_acc);

    // Random traffic; a request stays stable until the model says it was accepted
    ra_v = 1'b0; rm_v = 1'b0; ra_a = '0; rm_a = '0; ra_d = '0; rm_d = '0;
    a_acc = 1'b1; m_acc = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (!ra_v || a_acc) begin
        ra_v = ($urandom_range(0, 99) < 65);
        ra_a = 4'($urandom_range(0, 7));
        ra_d = 16'($urandom);
      end
      if (!rm_v || m_acc) begin
        rm_v = ($urandom_range(0, 99) < 65);
        rm_a = 4'($urandom_range(0, 7));
        rm_d = 16'($urandom);
      end
      cycle(ra_v, ra_a, ra_d, rm_v, rm_a, rm_d, a_acc, m_acc);
    end

    // Drain, bounded
    for (int c = 0; c < 20 && !model_idle(); c++)
      cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, a_acc, m_acc);
    cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, a_acc, m_acc);
    chk("final idle", 32'(idle), 32'd1);
    chk("final pend_mask", 32'(pend_mask), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port between two writeback requesters: the ALU writeback stage and the cache/memory load-return path. Each requester feeds a small per-requester FIFO. A round-robin arbiter drains the FIFOs into a registered write port that connects directly to the register file's `we` / `dst_addr` / `dst` inputs. A per-register pending mask goes to the stall logic, so instructions with outstanding writes are held in decode; the pipeline has no data forwarding.

## Interface
Parameters:
- `DATA_W`, 16, register width
- `ADDR_W`, 4, register address width (2^ADDR_W registers)
- `FIFO_DEPTH`, 2, entries per requester FIFO (power of two, ≥2)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `alu_vld`  in  1  ALU write request valid
- `alu_rdy`  out  1  ALU FIFO can accept
- `alu_addr`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU write data
- `mem_vld`  in  1  load-return write request valid
- `mem_rdy`  out  1  load FIFO can accept
- `mem_addr`  in  ADDR_W  load destination register
- `mem_data`  in  DATA_W  load write data
- `rf_we`  out  1  register-file write enable (registered)
- `rf_dst_addr`  out  ADDR_W  register-file write address (registered)
- `rf_dst`  out  DATA_W  register-file write data (registered)
- `pend_mask`  out  2^ADDR_W  bit i set while any write to register i is queued or on the port
- `idle`  out  1  both FIFOs empty and `rf_we` low; used to drain before halt dump

## Operation
- **Accept.** A request is accepted on an edge where `vld && rdy`.
  - `rdy = rst_n && !fifo_full`.
  - `vld` may be held without `rdy`. Data must remain stable until accepted.
- **Sequence tag.** Each accepted entry receives a tag from a free-running counter of width `$clog2(2*FIFO_DEPTH)+1`.
  - The counter advances by the number of entries accepted that edge.
  - When both requesters are accepted on the same edge, mem gets tag n and alu gets n+1. A load return is always older than a same-cycle ALU result.
- **Register 0.** Requests to register 0 are accepted and enqueued, but produce no `rf_we` pulse. They never set `pend_mask[0]`.
- **Arbitration.** Arbitration is evaluated each cycle over the two FIFO heads.
  - Only one head non-empty: grant it.
  - Both heads target the same address (WAW): grant the older tag. Age is compared modulo the counter width, so wrap-around is correct.
  - Otherwise: round-robin. The pointer flips to the non-granted requester after each grant. After reset, alu has priority.
- **Grant.** The granted head is popped, and the output registers load `{addr != 0, addr, data}`. With no grant, `rf_we` is 0 next cycle; addr and data hold their previous values.
- **Pending mask.** `pend_mask[i]` is the OR of:
  - any valid FIFO entry with addr == i (i ≠ 0), and
  - `rf_we && rf_dst_addr == i`.
  - It is combinational from state, not from inputs.
- **Simultaneous push and pop** on one FIFO: allowed when full. `rdy` reflects pre-pop occupancy, so there is no same-cycle pass-through.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FIFOs emptied; tag counter = 0; round-robin pointer = alu.
  - `rf_we` = 0, `rf_dst_addr` = 0, `rf_dst` = 0.
  - `pend_mask` = 0, `idle` = 1, `alu_rdy` = `mem_rdy` = 0 while `rst_n` is low.
  - Reset mid-operation discards all queued writes.
- **Latency.**
  - An entry accepted at edge E is arbitrated in the following cycle. With no contention, `rf_we` is high for the cycle starting at edge E+1.
  - The register file writes during that cycle's clock-high phase.
  - `pend_mask` bit sets the cycle after edge E. It clears the cycle after the `rf_we` cycle.
- **Throughput.** One register-file write per cycle. Each FIFO sustains one accept per cycle when the other FIFO is empty.
- **Full FIFO.** `rdy` drops to 0 the cycle after the FIFO fills. The requester must stall; no request is dropped.

## Structure
- Package `rf_arb_pkg`:
  - `DATA_W`, `ADDR_W`, and `NUM_REGS = 2**ADDR_W` constants.
  - Typedef `wb_entry_t` = `{addr, data, tag}`.
  - Function `older(tag_a, tag_b)` for the modular age compare.
- Sub-module `rf_wb_fifo`: parameterized `FIFO_DEPTH` entries of `wb_entry_t`, with push/pop, full/empty, and a flat entries+valid view exported for `pend_mask`. It is instantiated twice.
- Arbiter, tag counter, output register and mask logic live in the top module.

## Test plan
- **Reset.** Hold `rst_n` = 0 with `alu_vld` = 1 → both `rdy` = 0, `rf_we` = 0, `pend_mask` = 0. Release → `alu_rdy` = 1 on the next cycle.
- **Single write.** alu writes R3 = 16'hBEEF at edge E → `pend_mask` = 16'h0008 after E. Cycle after E+1: `rf_we` = 1, addr = 3, data = BEEF. Then `pend_mask` = 0 and `idle` = 1.
- **Contention, different registers.** Both requesters write R1 = 1111 (alu) and R2 = 2222 (mem) on the same edge → R1 is written first (rr reset priority alu), then R2. Two consecutive `rf_we` cycles.
- **WAW.** Same edge: mem R5 = AAAA, alu R5 = BBBB → AAAA is written first, BBBB second, regardless of the rr pointer. Repeat after the tag counter wraps → same order.
- **Backpressure.** alu pushes 3 entries back-to-back while mem keeps the port busy → `alu_rdy` = 0 after 2 entries. All 3 values are eventually written in order and none are lost.
- **R0 and mid-operation reset.**
  - Write to R0 → no `rf_we` pulse and `pend_mask[0]` stays 0.
  - Assert `rst_n` with 3 entries queued → `rf_we` = 0 immediately. After release, no stale writes appear.
